// File: rtl/deser_pkg.sv
// Shared widths and the closed-word payload for the serial-to-parallel deserializer.
package deser_pkg;

    localparam int unsigned DESER_DATA_W  = 16;
    localparam int unsigned DESER_LEN_W   = $clog2(DESER_DATA_W);
    localparam int unsigned DESER_MIN_LEN = 3;

    // Closed word: left-aligned data plus bit count (0 means a full word)
    typedef struct packed {
        logic [DESER_DATA_W-1:0] data;
        logic [DESER_LEN_W-1:0]  len;
    } deser_word_t;

endpackage

// File: rtl/deser_out_reg.sv
// One-entry valid/ready holding register; a word offered while full and not draining is dropped.
module deser_out_reg
    import deser_pkg::*;
(
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        load_i,
    input  deser_word_t word_i,
    input  logic        ready_i,
    output logic        val_o,
    output deser_word_t word_o,
    output logic        overrun_o
);

    logic        r_val;
    deser_word_t r_word;
    logic        r_overrun;
    logic        w_drain;
    logic        w_take;

    // Accept a new word when empty or when the current one leaves this same cycle
    assign w_drain = r_val && ready_i;
    assign w_take  = load_i && (!r_val || w_drain);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_val     <= 1'b0;
            r_word    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= load_i && r_val && !ready_i;
            if (w_take) begin
                r_val  <= 1'b1;
                r_word <= word_i;
            end else if (w_drain) begin
                r_val  <= 1'b0;
            end
        end
    end

    assign val_o     = r_val;
    assign word_o    = r_word;
    assign overrun_o = r_overrun;

endmodule

// File: rtl/deserializator.sv
// Rebuilds MSB-first serial frames into left-aligned words with a bit count; short frames close
// when valid drops, runts are discarded with a pulse.
module deserializator
    import deser_pkg::*;
#(
    parameter int unsigned DATA_W  = DESER_DATA_W,
    parameter int unsigned MIN_LEN = DESER_MIN_LEN
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,
    input  logic                      ser_data_i,
    input  logic                      ser_data_val_i,
    output logic [DATA_W-1:0]         deser_data_o,
    output logic [$clog2(DATA_W)-1:0] deser_len_o,
    output logic                      deser_data_val_o,
    input  logic                      deser_ready_i,
    output logic                      busy_o,
    output logic                      overrun_o,
    output logic                      runt_o
);

    localparam int unsigned LEN_W = $clog2(DATA_W);
    localparam int unsigned CNT_W = LEN_W + 1;

    logic [DATA_W-1:0] r_sreg;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_runt;

    logic [DATA_W-1:0] w_sreg_nxt;
    logic              w_full_close;
    logic              w_short_close;
    logic              w_runt;
    logic              w_load;
    deser_word_t       w_word;
    deser_word_t       w_held;

    // Close decode: full word on the DATA_W-th bit, short word on the first gap of a frame
    always_comb begin
        w_sreg_nxt    = {r_sreg[DATA_W-2:0], ser_data_i};
        w_full_close  = ser_data_val_i && (r_cnt == CNT_W'(DATA_W - 1));
        w_short_close = !ser_data_val_i && (r_cnt != '0);
        w_runt        = w_short_close && (r_cnt < CNT_W'(MIN_LEN));
        w_load        = (w_full_close || w_short_close) && !w_runt;
        w_word.data   = w_full_close ? w_sreg_nxt
                                     : (r_sreg << (CNT_W'(DATA_W) - r_cnt));
        w_word.len    = w_full_close ? '0 : LEN_W'(r_cnt);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_runt <= 1'b0;
        end else begin
            r_runt <= w_runt;
            if (ser_data_val_i) begin
                r_sreg <= w_sreg_nxt;
                r_cnt  <= w_full_close ? '0 : r_cnt + CNT_W'(1);
            end else begin
                r_cnt  <= '0;
            end
        end
    end

    deser_out_reg u_out_reg (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .load_i    (w_load),
        .word_i    (w_word),
        .ready_i   (deser_ready_i),
        .val_o     (deser_data_val_o),
        .word_o    (w_held),
        .overrun_o (overrun_o)
    );

    assign deser_data_o = w_held.data;
    assign deser_len_o  = w_held.len;
    assign busy_o       = (r_cnt != '0);
    assign runt_o       = r_runt;

endmodule

// File: tb/tb_deserializator.sv
// Directed and randomized bench for deserializator against a queue-based frame model.
module tb_deserializator;

    logic        clk     = 1'b0;
    logic        arstn   = 1'b0;
    logic        sd      = 1'b0;
    logic        sv      = 1'b0;
    logic        rdy     = 1'b0;
    logic [15:0] dout;
    logic [3:0]  dlen;
    logic        dval;
    logic        busy;
    logic        ovr;
    logic        runt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    deserializator dut (
        .clk_i            (clk),
        .arstn_i          (arstn),
        .ser_data_i       (sd),
        .ser_data_val_i   (sv),
        .deser_data_o     (dout),
        .deser_len_o      (dlen),
        .deser_data_val_o (dval),
        .deser_ready_i    (rdy),
        .busy_o           (busy),
        .overrun_o        (ovr),
        .runt_o           (runt)
    );

    // Reference model state: bits of the open frame and the expected holding register
    bit          q[$];
    logic        m_val  = 1'b0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_len  = '0;
    logic        m_ovr  = 1'b0;
    logic        m_runt = 1'b0;
    logic [15:0] acc_data[$];
    logic [3:0]  acc_len[$];
    int          dut_acc  = 0;
    int          ovr_seen = 0;
    int          runt_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs present at that edge
    task automatic model_step();
        bit          close;
        bit          drain;
        bit          loaded;
        int          n;
        logic [15:0] w;
        close  = 0;
        loaded = 0;
        m_ovr  = 1'b0;
        m_runt = 1'b0;
        drain  = m_val && rdy;
        if (drain) begin
            acc_data.push_back(m_data);
            acc_len.push_back(m_len);
        end
        if (sv) begin
            q.push_back(sd);
            if (q.size() == 16) close = 1;
        end else if (q.size() != 0) begin
            close = 1;
        end
        if (close) begin
            n = q.size();
            w = '0;
            for (int i = 0; i < n; i++) w[15-i] = q[i];
            q.delete();
            if (n < 3) begin
                m_runt = 1'b1;
            end else if (!m_val || drain) begin
                m_val  = 1'b1;
                m_data = w;
                m_len  = 4'(n % 16);
                loaded = 1;
            end else begin
                m_ovr = 1'b1;
            end
        end
        if (drain && !loaded) m_val = 1'b0;
    endtask

    task automatic compare_all();
        check("val", 32'(dval), 32'(m_val));
        check("busy", 32'(busy), 32'(q.size() != 0));
        check("overrun", 32'(ovr), 32'(m_ovr));
        check("runt", 32'(runt), 32'(m_runt));
        if (m_val) begin
            check("data", 32'(dout), 32'(m_data));
            check("len", 32'(dlen), 32'(m_len));
        end
        if (ovr === 1'b1) ovr_seen++;
        if (runt === 1'b1) runt_seen++;
    endtask

    task automatic tick(input logic v, input logic d, input logic r);
        sv  = v;
        sd  = d;
        rdy = r;
        if (dval === 1'b1 && r) dut_acc++;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic send_frame(input logic [15:0] w, input int nbits, input logic r);
        for (int i = 0; i < nbits; i++) begin
            logic [15:0] tmp;
            tmp = w;
            tick(1'b1, tmp[15-i], r);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_val"}, 32'(dval), 32'd0);
        check({tag, "_data"}, 32'(dout), 32'd0);
        check({tag, "_len"}, 32'(dlen), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ovr"}, 32'(ovr), 32'd0);
        check({tag, "_runt"}, 32'(runt), 32'd0);
    endtask

    // Assert reset mid-cycle, hold across two edges, release mid-cycle
    task automatic do_reset();
        arstn = 1'b0;
        sv    = 1'b0;
        sd    = 1'b0;
        #1;
        check_reset_outputs("rst_now");
        q.delete();
        m_val  = 1'b0;
        m_data = '0;
        m_len  = '0;
        m_ovr  = 1'b0;
        m_runt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        arstn = 1'b1;
    endtask

    int n0;
    int ov0;
    int rn0;

    initial begin
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        arstn = 1'b1;

        // 1: full word
        n0 = acc_data.size();
        send_frame(16'hA5C3, 16, 1'b1);
        check("t1_val_now", 32'(dval), 32'd1);
        tick(1'b0, 1'b0, 1'b1);
        check("t1_count", 32'(acc_data.size() - n0), 32'd1);
        check("t1_data", 32'(acc_data[acc_data.size()-1]), 32'h0000A5C3);
        check("t1_len", 32'(acc_len[acc_len.size()-1]), 32'd0);
        check("t1_val_gone", 32'(dval), 32'd0);

        // 2: short frame
        n0 = acc_data.size();
        send_frame(16'hB000, 5, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("t2_val_rise", 32'(dval), 32'd1);
        tick(1'b0, 1'b0, 1'b1);
        check("t2_count", 32'(acc_data.size() - n0), 32'd1);
        check("t2_data", 32'(acc_data[acc_data.size()-1]), 32'h0000B000);
        check("t2_len", 32'(acc_len[acc_len.size()-1]), 32'd5);

        // 3: runt
        n0  = acc_data.size();
        rn0 = runt_seen;
        send_frame(16'hC000, 2, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        check("t3_count", 32'(acc_data.size() - n0), 32'd0);
        check("t3_runts", 32'(runt_seen - rn0), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);

        // 4: backpressure with overrun
        n0  = acc_data.size();
        ov0 = ovr_seen;
        send_frame(16'h1234, 16, 1'b0);
        send_frame(16'h5678, 16, 1'b0);
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        check("t4_hold", 32'(dout), 32'h00001234);
        check("t4_ovr", 32'(ovr_seen - ov0), 32'd1);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        check("t4_count", 32'(acc_data.size() - n0), 32'd1);
        check("t4_data", 32'(acc_data[acc_data.size()-1]), 32'h00001234);

        // 5: streaming
        n0  = acc_data.size();
        ov0 = ovr_seen;
        send_frame(16'h1111, 16, 1'b1);
        send_frame(16'h2222, 16, 1'b1);
        send_frame(16'h3333, 16, 1'b1);
        repeat (2) tick(1'b0, 1'b0, 1'b1);
        check("t5_count", 32'(acc_data.size() - n0), 32'd3);
        check("t5_w0", 32'(acc_data[n0]), 32'h00001111);
        check("t5_w1", 32'(acc_data[n0+1]), 32'h00002222);
        check("t5_w2", 32'(acc_data[n0+2]), 32'h00003333);
        check("t5_ovr", 32'(ovr_seen - ov0), 32'd0);

        // 6: reset with a held word and a partial frame
        send_frame(16'hDEAD, 16, 1'b0);
        send_frame(16'hFFFF, 9, 1'b0);
        do_reset();
        n0 = acc_data.size();
        send_frame(16'h0F0F, 16, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("t6_count", 32'(acc_data.size() - n0), 32'd1);
        check("t6_data", 32'(acc_data[acc_data.size()-1]), 32'h00000F0F);

        // Randomized traffic with bursty valid and ready
        for (int c = 0; c < 3000; c++) begin
            logic v;
            logic r;
            v = ($urandom % 10) < ((c / 300) % 2 == 0 ? 8 : 5);
            r = ($urandom % 10) < ((c / 500) % 2 == 0 ? 7 : 3);
            tick(v, 1'($urandom), r);
        end
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        check("rand_accepts", 32'(dut_acc), 32'(acc_data.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
